// File: rtl/reg_file_master.sv
// Command/response master for a synchronous register file with a one-cycle read latency.
// Define REG_MASTER_WR_VERIFY_EN to follow every write with a readback and flag mismatches.
module reg_file_master #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CmdValid,
    output logic                  CmdReady,
    input  logic                  CmdWrite,
    input  logic [ADDR_WIDTH-1:0] CmdAddr,
    input  logic [DATA_WIDTH-1:0] CmdWrData,
    output logic                  RspValid,
    input  logic                  RspReady,
    output logic [DATA_WIDTH-1:0] RspData,
    output logic                  RspErr,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData
);

`ifdef REG_MASTER_WR_VERIFY_EN
    localparam bit VerifyEn = 1'b1;
`else
    localparam bit VerifyEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StRdWait,
        StVRead,
        StVWait,
        StResp
    } state_e;

    state_e state_q;

    // Address and WrData double as the latched command fields for the whole transaction.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            CmdReady <= 1'b0;
            RspValid <= 1'b0;
            RspErr   <= 1'b0;
            RspData  <= '0;
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            Address  <= '0;
            WrData   <= '0;
        end else begin
            WrEn <= 1'b0;
            RdEn <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (CmdValid && CmdReady) begin
                        CmdReady <= 1'b0;
                        Address  <= CmdAddr;
                        WrData   <= CmdWrData;
                        if (CmdWrite) begin
                            WrEn    <= 1'b1;
                            state_q <= StWrite;
                        end else begin
                            RdEn    <= 1'b1;
                            state_q <= StRead;
                        end
                    end else begin
                        CmdReady <= 1'b1;
                    end
                end
                StWrite: begin
                    if (VerifyEn) begin
                        RdEn    <= 1'b1;
                        state_q <= StVRead;
                    end else begin
                        RspValid <= 1'b1;
                        RspData  <= '0;
                        RspErr   <= 1'b0;
                        state_q  <= StResp;
                    end
                end
                StRead: begin
                    state_q <= StRdWait;
                end
                StRdWait: begin
                    RspValid <= 1'b1;
                    RspData  <= RdData;
                    RspErr   <= 1'b0;
                    state_q  <= StResp;
                end
                StVRead: begin
                    state_q <= StVWait;
                end
                StVWait: begin
                    RspValid <= 1'b1;
                    RspData  <= '0;
                    RspErr   <= VerifyEn && (RdData != WrData);
                    state_q  <= StResp;
                end
                StResp: begin
                    if (RspReady) begin
                        RspValid <= 1'b0;
                        CmdReady <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    CmdReady <= 1'b0;
                    RspValid <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_master.sv
// Directed self-checking bench for reg_file_master with a behavioural register-file model.
module tb_reg_file_master;

    localparam int Budget = 20;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CmdValid;
    logic        CmdReady;
    logic        CmdWrite;
    logic [3:0]  CmdAddr;
    logic [15:0] CmdWrData;
    logic        RspValid;
    logic        RspReady;
    logic [15:0] RspData;
    logic        RspErr;
    logic        WrEn;
    logic        RdEn;
    logic [3:0]  Address;
    logic [15:0] WrData;
    logic [15:0] RdData;

    int checks = 0;
    int failures = 0;

    logic [15:0] mem [16];
    bit          corrupt_en = 1'b0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          rsp_cnt = 0;
    int          both_cnt = 0;
    logic [3:0]  last_wr_addr;
    logic [15:0] last_wr_data;

    reg_file_master #(
        .ADDR_WIDTH(4),
        .DATA_WIDTH(16)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CmdValid (CmdValid),
        .CmdReady (CmdReady),
        .CmdWrite (CmdWrite),
        .CmdAddr  (CmdAddr),
        .CmdWrData(CmdWrData),
        .RspValid (RspValid),
        .RspReady (RspReady),
        .RspData  (RspData),
        .RspErr   (RspErr),
        .WrEn     (WrEn),
        .RdEn     (RdEn),
        .Address  (Address),
        .WrData   (WrData),
        .RdData   (RdData)
    );

    always #5 CLK = ~CLK;

    // Register file with one-cycle read latency; addr 7 flips a bit when corruption is on.
    always @(posedge CLK) begin
        if (WrEn) begin
            mem[Address] <= (corrupt_en && Address == 4'd7) ? (WrData ^ 16'h0100) : WrData;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= Address;
            last_wr_data <= WrData;
        end
        if (RdEn) begin
            RdData <= mem[Address];
            rd_cnt <= rd_cnt + 1;
        end
        if (WrEn && RdEn) both_cnt <= both_cnt + 1;
        if (RspValid && RspReady) rsp_cnt <= rsp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic wr, input logic [3:0] a, input logic [15:0] d,
                          input bit keep);
        int n = 0;
        CmdValid  = 1'b1;
        CmdWrite  = wr;
        CmdAddr   = a;
        CmdWrData = d;
        while (!CmdReady && n < Budget) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!CmdReady) chk("accept_timeout", 32'(n), 32'(Budget - 1));
        else begin
            @(posedge CLK); #1;
        end
        if (!keep) CmdValid = 1'b0;
    endtask

    task automatic wait_rsp(input bit do_hs, output logic [15:0] data, output logic err,
                            output int lat);
        int n = 0;
        while (!RspValid && n < Budget) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!RspValid) chk("rsp_timeout", 32'(n), 32'(Budget - 1));
        data = RspData;
        err  = RspErr;
        lat  = n + 1;
        if (do_hs) begin
            @(posedge CLK); #1;
        end
    endtask

    function automatic logic [15:0] pat(input int i);
        return 16'(i * 4369) ^ 16'h5A0F;
    endfunction

    initial begin
        logic [15:0] d;
        logic        e;
        int          lat;
        int          wr0, rd0, rsp0;

        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        RdData    = 16'h0000;
        RST       = 1'b1;
        CmdValid  = 1'b0;
        CmdWrite  = 1'b0;
        CmdAddr   = 4'h0;
        CmdWrData = 16'h0000;
        RspReady  = 1'b1;

        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_cmdready", 32'(CmdReady), 32'd0);
        chk("rst_rspvalid", 32'(RspValid), 32'd0);
        chk("rst_strobes", {30'd0, WrEn, RdEn}, 32'd0);
        chk("rst_address", 32'(Address), 32'd0);
        chk("rst_wrdata", 32'(WrData), 32'd0);
        chk("rst_rspdata_err", {15'd0, RspData, RspErr}, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_cmdready", 32'(CmdReady), 32'd1);

        // Reset mid-write aborts the transaction
        wr0 = wr_cnt; rsp0 = rsp_cnt;
        accept(1'b1, 4'd4, 16'hBEEF, 1'b0);
        chk("midwr_wren", 32'(WrEn), 32'd1);
        RST = 1'b1;
        repeat (2) begin
            @(posedge CLK); #1;
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("midwr_wren_after", 32'(WrEn), 32'd0);
        chk("midwr_rspvalid", 32'(RspValid), 32'd0);
        chk("midwr_cmdready", 32'(CmdReady), 32'd1);
        repeat (3) @(posedge CLK);
        #1;
        chk("midwr_wr_pulses", 32'(wr_cnt - wr0), 32'd1);
        chk("midwr_no_rsp", 32'(rsp_cnt - rsp0), 32'd0);

        // Write then read addr 2
        wr0 = wr_cnt;
        accept(1'b1, 4'd2, 16'h0003, 1'b0);
        wait_rsp(1'b1, d, e, lat);
        chk("wr2_pulses", 32'(wr_cnt - wr0), 32'd1);
        chk("wr2_addr", 32'(last_wr_addr), 32'd2);
        chk("wr2_data", 32'(last_wr_data), 32'h0003);
        chk("wr2_rspdata", 32'(d), 32'd0);
        chk("wr2_rsperr", 32'(e), 32'd0);
`ifdef REG_MASTER_WR_VERIFY_EN
        chk("wr2_latency", 32'(lat), 32'd4);
`else
        chk("wr2_latency", 32'(lat), 32'd2);
`endif
        chk("wr2_cmdready_after", 32'(CmdReady), 32'd1);
        accept(1'b0, 4'd2, 16'hFFFF, 1'b0);
        wait_rsp(1'b1, d, e, lat);
        chk("rd2_data", 32'(d), 32'h0003);
        chk("rd2_err", 32'(e), 32'd0);
        chk("rd2_latency", 32'(lat), 32'd3);

        // Backpressure on the response
        accept(1'b1, 4'd5, 16'h1234, 1'b0);
        wait_rsp(1'b1, d, e, lat);
        RspReady = 1'b0;
        accept(1'b0, 4'd5, 16'h0000, 1'b0);
        wait_rsp(1'b0, d, e, lat);
        wr0 = wr_cnt; rd0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("bp_rspvalid", 32'(RspValid), 32'd1);
            chk("bp_rspdata", 32'(RspData), 32'h1234);
            chk("bp_cmdready", 32'(CmdReady), 32'd0);
        end
        chk("bp_no_strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
        RspReady = 1'b1;
        @(posedge CLK); #1;
        chk("bp_rspvalid_done", 32'(RspValid), 32'd0);
        chk("bp_cmdready_done", 32'(CmdReady), 32'd1);

`ifdef REG_MASTER_WR_VERIFY_EN
        // Write-verify against a corrupting register file
        corrupt_en = 1'b1;
        accept(1'b1, 4'd7, 16'hA5A5, 1'b0);
        wait_rsp(1'b1, d, e, lat);
        chk("vfy7_err", 32'(e), 32'd1);
        chk("vfy7_data", 32'(d), 32'd0);
        accept(1'b1, 4'd6, 16'hA5A5, 1'b0);
        wait_rsp(1'b1, d, e, lat);
        chk("vfy6_err", 32'(e), 32'd0);
        corrupt_en = 1'b0;
`else
        accept(1'b1, 4'd7, 16'hA5A5, 1'b0);
        wait_rsp(1'b1, d, e, lat);
        chk("nvfy7_err", 32'(e), 32'd0);
        chk("nvfy7_latency", 32'(lat), 32'd2);
`endif

        // Back-to-back with CmdValid held high
        for (int i = 0; i < 16; i++) begin
            accept(1'b1, 4'(i), pat(i), 1'b1);
            wait_rsp(1'b1, d, e, lat);
            accept(1'b0, 4'(i), 16'h0000, 1'b1);
            wait_rsp(1'b1, d, e, lat);
            chk($sformatf("b2b_rd%0d", i), 32'(d), 32'(pat(i)));
        end
        CmdValid = 1'b0;
        chk("b2b_no_overlap", 32'(both_cnt), 32'd0);

        // CmdValid pulsed during RDWAIT is ignored
        wr0 = wr_cnt; rd0 = rd_cnt; rsp0 = rsp_cnt;
        accept(1'b0, 4'd3, 16'h0000, 1'b0);
        @(posedge CLK); #1;
        CmdValid  = 1'b1;
        CmdWrite  = 1'b1;
        CmdAddr   = 4'd9;
        CmdWrData = 16'hDEAD;
        @(posedge CLK); #1;
        CmdValid = 1'b0;
        wait_rsp(1'b1, d, e, lat);
        chk("ign_rd_data", 32'(d), 32'(pat(3)));
        repeat (5) @(posedge CLK);
        #1;
        chk("ign_wr_strobes", 32'(wr_cnt - wr0), 32'd0);
        chk("ign_rd_strobes", 32'(rd_cnt - rd0), 32'd1);
        chk("ign_responses", 32'(rsp_cnt - rsp0), 32'd1);
        chk("ign_mem9", 32'(mem[9]), 32'(pat(9)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
